// File: rtl/fetch_sequencer.sv
// Front-end stage of the 4-bit processor: program counter, fetch register,
// fetch/execute phase and C/Z flags feeding the microcode decoder ROM.
module fetch_sequencer #(
  parameter int              PC_W   = 12,
  parameter logic [PC_W-1:0] RST_PC = 12'h000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [7:0]      prog_byte,
  input  logic            inc_pc,
  input  logic            load_pc,
  input  logic            load_flags,
  input  logic            alu_c,
  input  logic            alu_z,
  output logic [PC_W-1:0] pc_out,
  output logic [6:0]      rom_addr,
  output logic [3:0]      instr,
  output logic [3:0]      oprnd,
  output logic [PC_W-1:0] target,
  output logic            phase,
  output logic            c_flag,
  output logic            z_flag
);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  phase_t          r_phase;
  phase_t          w_phase_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [7:0]      r_fetch;
  logic [7:0]      w_fetch_nxt;
  logic            r_c;
  logic            r_z;
  logic            w_c_nxt;
  logic            w_z_nxt;
  logic [PC_W-1:0] w_target;

  // Jump target is only meaningful with PC_W == 12 (operand nibble + one byte).
  assign w_target = {r_fetch[3:0], prog_byte};

  // Phase state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_FETCH;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // Phase next-state: alternate fetch/execute on every enabled edge.
  always_comb begin
    w_phase_nxt = r_phase;
    if (en) begin
      case (r_phase)
        PH_FETCH: w_phase_nxt = PH_EXEC;
        PH_EXEC:  w_phase_nxt = PH_FETCH;
        default:  w_phase_nxt = PH_FETCH;
      endcase
    end else begin
      w_phase_nxt = r_phase;
    end
  end

  // PC, fetch register and flag next-state; load_pc outranks inc_pc.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_fetch_nxt = r_fetch;
    w_c_nxt     = r_c;
    w_z_nxt     = r_z;
    if (en) begin
      if (r_phase == PH_FETCH) begin
        w_fetch_nxt = prog_byte;
      end else begin
        w_fetch_nxt = r_fetch;
      end
      if (load_pc) begin
        w_pc_nxt = w_target;
      end else if (inc_pc) begin
        w_pc_nxt = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
      end else begin
        w_pc_nxt = r_pc;
      end
      if (load_flags) begin
        w_c_nxt = alu_c;
        w_z_nxt = alu_z;
      end else begin
        w_c_nxt = r_c;
        w_z_nxt = r_z;
      end
    end else begin
      w_pc_nxt    = r_pc;
      w_fetch_nxt = r_fetch;
      w_c_nxt     = r_c;
      w_z_nxt     = r_z;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RST_PC;
      r_fetch <= 8'h00;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_fetch <= w_fetch_nxt;
      r_c     <= w_c_nxt;
      r_z     <= w_z_nxt;
    end
  end

  assign pc_out   = r_pc;
  assign instr    = r_fetch[7:4];
  assign oprnd    = r_fetch[3:0];
  assign target   = w_target;
  assign phase    = r_phase;
  assign c_flag   = r_c;
  assign z_flag   = r_z;
  assign rom_addr = {r_fetch[7:4], r_c, r_z, r_phase};

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end stage of the 4-bit processor. Holds the program counter, fetch register, phase flip-flop and C/Z flags.
- Drives the 7-bit microcode address {instr[3:0], c_flag, z_flag, phase} into the microcode decoder ROM.
- Consumes the decoder's inc_pc, load_pc and load_flags control bits.
- Presents the operand nibble and the 12-bit jump/RAM address to the datapath.

Parameters:
- PC_W, 12, program counter and jump target width. PC_W-8 must equal 4 (operand nibble plus one byte).
- RST_PC, 12'h000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; 0 freezes all state.
- prog_byte  in  8  program ROM data at address pc_out (combinational ROM outside this block).
- inc_pc  in  1  from decoder Y[12]: increment PC.
- load_pc  in  1  from decoder Y[11]: load jump target into PC.
- load_flags  in  1  from decoder: capture ALU flags.
- alu_c  in  1  ALU carry result.
- alu_z  in  1  ALU zero result.
- pc_out  out  12  program counter, to program ROM address.
- rom_addr  out  7  decoder address {instr, c_flag, z_flag, phase}.
- instr  out  4  fetch register upper nibble (opcode).
- oprnd  out  4  fetch register lower nibble (operand/immediate).
- target  out  12  {oprnd, prog_byte}; jump target and RAM address.
- phase  out  1  0 = fetch, 1 = execute.
- c_flag  out  1  registered carry.
- z_flag  out  1  registered zero.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle, mid-instruction included): pc = RST_PC, fetch register = 8'h00, phase = 0, c_flag = 0, z_flag = 0. rom_addr = 7'b0000000.
- Reset release is synchronised by the integrator. The first active edge after release is a fetch edge.
- en = 0: no register changes; outputs hold. Decoder inputs are ignored.
- Phase: toggles on every enabled edge (0 -> 1 -> 0 ...). No other state; no illegal states.
- Fetch register: loads prog_byte only on an enabled edge with phase = 0. Holds during phase = 1.
- PC update on an enabled edge, in priority order:
  - load_pc = 1: pc <= target, i.e. {oprnd, prog_byte} sampled that cycle.
  - otherwise inc_pc = 1: pc <= pc + 1, modulo 2^12 (12'hFFF wraps to 12'h000, no flag).
  - otherwise pc holds.
  - load_pc and inc_pc both 1: load wins.
- load_pc is honoured in either phase. The decoder only asserts it in phase 1.
- Flags: on an enabled edge with load_flags = 1, c_flag <= alu_c and z_flag <= alu_z. Otherwise hold. Phase is not checked.
- Combinational outputs, with no added latency:
  - rom_addr = {instr, c_flag, z_flag, phase}.
  - target = {oprnd, prog_byte}.
  - pc_out = pc.
- Per-instruction timeline, 2 cycles:
  - Cycle F (phase 0): decoder sees opcode from the previous fetch with phase bit 0 and asserts inc_pc. At the edge: fetch <= ROM[pc], pc <= pc+1, phase <= 1.
  - Cycle E (phase 1): decoder sees the new opcode and flags. prog_byte = ROM[pc], the second byte. At the edge: jump, increment or hold per the decoder; flags optionally loaded; phase <= 0.
- Flag-dependent branches use flags registered before cycle E. A load_flags in the same E cycle affects only the next instruction.
- Decoder X outputs (default case) are not filtered. The bench treats X on inc_pc/load_pc as an error.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with pc = 12'h3A5, phase = 1 -> immediately pc_out = 0, phase = 0, rom_addr = 7'h00, flags 0. After release with inc_pc = 1, pc_out = 1 and phase = 1 after one edge.
- Fetch/decode: prog_byte = 8'h7C at pc 0 in phase 0 -> after edge instr = 4'h7, oprnd = 4'hC, rom_addr = 7'b0111_00_1, pc = 1.
- Jump: phase 1, instr/oprnd = 8'h42, prog_byte = 8'h10, load_pc = 1, inc_pc = 1 -> pc = 12'h210 and phase = 0 next edge.
- Wrap: pc = 12'hFFF, inc_pc = 1 -> pc = 12'h000.
- Flags: load_flags = 1, alu_c = 1, alu_z = 0 -> c_flag = 1, z_flag = 0 and rom_addr bits [2:1] = 2'b10 next cycle. load_flags = 0 with alu inputs toggling -> flags hold.
- Stall: en = 0 for 3 cycles with inc_pc = load_pc = load_flags = 1 -> pc, fetch register, phase and flags unchanged. Resumes correctly when en returns to 1.
